// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer_pkg
//  Brief    : Shared types and constants for the program-counter sequencer:
//             FSM state encoding, opcode values, HALT encoding, bus widths.
//  Revision : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int OFFSET_W_DEF = 6;

   // PAUSE is only reachable when single-step support is compiled in.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4,
      ST_PAUSE  = 3'd5
   } state_t;

   localparam logic [1:0] OP_ALU  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_BRZ  = 2'b10;
   localparam logic [1:0] OP_J    = 2'b11;

   localparam logic [7:0] HALT_INSN = 8'hFF;

   // ALU and LOAD are the only opcodes that write the register file.
   function automatic logic op_writes(input logic [1:0] op);
      return (op == OP_ALU) || (op == OP_LOAD);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_sign_extender.sv
`default_nettype none
// ============================================================================
//  Module   : sign_extender
//  Brief    : Combinational sign extension of an IN_W-bit immediate to OUT_W
//             bits by replicating its top bit.
//  Revision : 1.0 - initial release
// ============================================================================
module sign_extender #(
   parameter int IN_W  = 6,
   parameter int OUT_W = 8
) (
   input  logic [IN_W-1:0]  in_val,
   output logic [OUT_W-1:0] out_val
);

   assign out_val = {{(OUT_W-IN_W){in_val[IN_W-1]}}, in_val};

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Brief    : Multi-cycle FETCH/DECODE/EXEC controller owning the program
//             counter. Feeds the external jump adder and loads its result on
//             taken branches; strobes register-file writes for ALU/LOAD.
//             Optional macro PC_SEQUENCER_SINGLE_STEP_EN adds a Step input and
//             a PAUSE state so each Step rising edge runs one instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int               DATA_W   = DATA_W_DEF,
   parameter int               OFFSET_W = OFFSET_W_DEF,
   parameter logic [DATA_W-1:0] RESET_PC = '0
) (
   input  logic              Clock,
   input  logic              Clear,
   input  logic              Run,
   input  logic [DATA_W-1:0] Instruction,
   input  logic              Mem_Ready,
   input  logic              Zero,
   input  logic [DATA_W-1:0] Jump_Address,
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
   input  logic              Step,
`endif
   output logic [DATA_W-1:0] PC,
   output logic [DATA_W-1:0] PC_Added,
   output logic [DATA_W-1:0] Sign_Extended_Instruction,
   output logic              Fetch_Req,
   output logic              Reg_Write,
   output logic              Halted
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] pc_added_q, pc_added_d;
   logic [DATA_W-1:0] sext_q, sext_d;
   logic              fetch_req_q, fetch_req_d;
   logic              reg_write_q, reg_write_d;
   logic              halted_q, halted_d;
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
   logic              step_q, step_d;
`endif

   logic [DATA_W-1:0] w_sext;
   logic [1:0]        w_op;
   logic              w_is_halt;
   logic              w_taken;

   sign_extender #(
      .IN_W  (OFFSET_W),
      .OUT_W (DATA_W)
   ) u_sign_extender (
      .in_val  (ir_q[OFFSET_W-1:0]),
      .out_val (w_sext)
   );

   assign w_op      = ir_q[DATA_W-1 -: 2];
   assign w_is_halt = (ir_q == DATA_W'(HALT_INSN));
   assign w_taken   = (w_op == OP_J) || ((w_op == OP_BRZ) && Zero);

   // Next-state and registered-output computation; everything holds by default.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      pc_added_d  = pc_added_q;
      sext_d      = sext_q;
      reg_write_d = 1'b0;
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
      step_d      = Step;
`endif
      case (state_q)
         ST_IDLE: begin
            if (Run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (Mem_Ready) begin
               ir_d    = Instruction;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (w_is_halt) begin
               state_d = ST_HALT;
            end else begin
               pc_added_d  = pc_q + DATA_W'(1);
               sext_d      = w_sext;
               // Strobe is registered so it is high exactly during EXEC.
               reg_write_d = op_writes(w_op);
               state_d     = ST_EXEC;
            end
         end
         ST_EXEC: begin
            pc_d = w_taken ? Jump_Address : pc_added_q;
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
            state_d = Run ? ST_PAUSE : ST_IDLE;
`else
            state_d = Run ? ST_FETCH : ST_IDLE;
`endif
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
         ST_PAUSE: begin
            if (Step && !step_q) state_d = ST_FETCH;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      fetch_req_d = (state_d == ST_FETCH);
      halted_d    = (state_d == ST_HALT);
   end

   // State and datapath registers; Clear discards any in-flight instruction.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         pc_added_q  <= '0;
         sext_q      <= '0;
         fetch_req_q <= 1'b0;
         reg_write_q <= 1'b0;
         halted_q    <= 1'b0;
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
         step_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         pc_added_q  <= pc_added_d;
         sext_q      <= sext_d;
         fetch_req_q <= fetch_req_d;
         reg_write_q <= reg_write_d;
         halted_q    <= halted_d;
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
         step_q      <= step_d;
`endif
      end
   end

   assign PC                        = pc_q;
   assign PC_Added                  = pc_added_q;
   assign Sign_Extended_Instruction = sext_q;
   assign Fetch_Req                 = fetch_req_q;
   assign Reg_Write                 = reg_write_q;
   assign Halted                    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Brief    : Self-checking bench for pc_sequencer. Instruction memory and the
//             jump adder are modelled around the DUT; expected PCs come from
//             an arithmetic model of the instruction set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       clear, run, mem_ready, zero, step;
   logic [7:0] instruction, jump_address;
   logic [7:0] pc, pc_added, sext;
   logic       fetch_req, reg_write, halted;
   logic [7:0] imem [256];

   int tests = 0;
   int fails = 0;
   int exp_pc;
   int exp_added;

   always #5 clk = ~clk;

   assign instruction  = imem[pc];
   assign jump_address = pc_added + sext;

   pc_sequencer #(
      .DATA_W   (8),
      .OFFSET_W (6),
      .RESET_PC (8'h00)
   ) dut (
      .Clock                     (clk),
      .Clear                     (clear),
      .Run                       (run),
      .Instruction               (instruction),
      .Mem_Ready                 (mem_ready),
      .Zero                      (zero),
      .Jump_Address              (jump_address),
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
      .Step                      (step),
`endif
      .PC                        (pc),
      .PC_Added                  (pc_added),
      .Sign_Extended_Instruction (sext),
      .Fetch_Req                 (fetch_req),
      .Reg_Write                 (reg_write),
      .Halted                    (halted)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: target = PC+1 + signed 6-bit offset, everything mod 256.
   function automatic int signed_offset(input logic [7:0] insn);
      int off;
      off = int'(insn[5:0]);
      return (off >= 32) ? off - 64 : off;
   endfunction

   function automatic int model_next_pc(input int cur, input logic [7:0] insn, input bit z);
      int op;
      op = int'(insn[7:6]);
      if (op == 3 || (op == 2 && z))
         return (cur + 1 + signed_offset(insn)) & 255;
      return (cur + 1) & 255;
   endfunction

   task automatic apply_reset();
      clear = 1'b1; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; step = 1'b0;
      #3;
      @(negedge clk);
      clear = 1'b0;
      exp_pc = 0;
      exp_added = 0;
   endtask

   // From IDLE, raise Run and expect FETCH after one edge.
   task automatic start_run();
      run = 1'b1;
      tick();
      tests++;
      if (fetch_req !== 1'b1) begin
         fails++;
         $display("FAIL start_fetch: fetch_req=%b required 1", fetch_req);
      end
   endtask

   // Runs one instruction from the current FETCH cycle, with 'stall' cycles of
   // Mem_Ready=0, Zero=z in EXEC, and Run forced to run_level at FETCH entry.
   task automatic do_instruction(input int stall, input bit z, input bit run_level);
      logic [7:0] insn, e_pc, e_sext, e_added;
      bit         wr;
      int         nxt;
      insn = imem[exp_pc[7:0]];
      run  = run_level;
      for (int i = 0; i < stall; i++) begin
         mem_ready = 1'b0;
         tests++;
         if (fetch_req !== 1'b1 || pc !== 8'(exp_pc)) begin
            fails++;
            $display("FAIL stall_hold: fetch_req=%b pc=%h required 1 and %h", fetch_req, pc, 8'(exp_pc));
         end
         tick();
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tests++;
      if (fetch_req !== 1'b0 || reg_write !== 1'b0) begin
         fails++;
         $display("FAIL decode_outputs: fetch_req=%b reg_write=%b required 0 0", fetch_req, reg_write);
      end
      if (insn == 8'hFF) begin
         tick();
         tests++;
         if (halted !== 1'b1 || pc !== 8'(exp_pc)) begin
            fails++;
            $display("FAIL halt_entry: halted=%b pc=%h required 1 and %h", halted, pc, 8'(exp_pc));
         end
         return;
      end
      wr      = (insn[7:6] == 2'b00) || (insn[7:6] == 2'b01);
      e_added = 8'((exp_pc + 1) & 255);
      e_sext  = 8'(signed_offset(insn) & 255);
      zero = z;
      tick();
      tests++;
      if (reg_write !== wr) begin
         fails++;
         $display("FAIL exec_reg_write: insn=%h got %b required %b", insn, reg_write, wr);
      end
      tests++;
      if (pc_added !== e_added || sext !== e_sext) begin
         fails++;
         $display("FAIL exec_operands: pc_added=%h sext=%h required %h %h", pc_added, sext, e_added, e_sext);
      end
      nxt = model_next_pc(exp_pc, insn, z);
      e_pc = 8'(nxt);
      tick();
      tests++;
      if (pc !== e_pc || reg_write !== 1'b0) begin
         fails++;
         $display("FAIL next_pc: insn=%h z=%b pc=%h reg_write=%b required %h 0", insn, z, pc, reg_write, e_pc);
      end
      exp_added = (exp_pc + 1) & 255;
      exp_pc = nxt;
`ifdef PC_SEQUENCER_SINGLE_STEP_EN
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (fetch_req !== 1'b0 || pc !== e_pc) begin
            fails++;
            $display("FAIL pause_hold: fetch_req=%b pc=%h required 0 and %h", fetch_req, pc, e_pc);
         end
         tick();
      end
      if (run_level) begin
         step = 1'b1;
         tick();
         step = 1'b0;
         tests++;
         if (fetch_req !== 1'b1) begin
            fails++;
            $display("FAIL step_resume: fetch_req=%b required 1", fetch_req);
         end
      end
`else
      tests++;
      if (fetch_req !== run_level) begin
         fails++;
         $display("FAIL after_exec_state: fetch_req=%b required %b", fetch_req, run_level);
      end
`endif
   endtask

   task automatic test_reset();
      apply_reset();
      tests++;
      if (pc !== 8'h00 || pc_added !== 8'h00 || sext !== 8'h00) begin
         fails++;
         $display("FAIL reset_datapath: pc=%h pc_added=%h sext=%h required 00 00 00", pc, pc_added, sext);
      end
      tests++;
      if (fetch_req !== 1'b0 || reg_write !== 1'b0 || halted !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: fetch_req=%b reg_write=%b halted=%b required 0 0 0", fetch_req, reg_write, halted);
      end
      for (int i = 0; i < 3; i++) tick();
      tests++;
      if (fetch_req !== 1'b0) begin
         fails++;
         $display("FAIL idle_without_run: fetch_req=%b required 0", fetch_req);
      end
   endtask

   task automatic test_sequence();
      apply_reset();
      imem[0] = 8'h00;
      imem[1] = 8'h40;
      start_run();
      do_instruction(0, 1'b0, 1'b1);
      do_instruction(0, 1'b0, 1'b1);
   endtask

   task automatic test_branch_and_wrap();
      apply_reset();
      imem[8'h00] = 8'hC4;   // J -> 05
      imem[8'h05] = 8'hBE;   // BRZ -2
      imem[8'h04] = 8'hC0;   // J -> 05
      imem[8'h06] = 8'hF6;   // J -> FD
      imem[8'hFD] = 8'hC5;   // J -> 03 (wraps)
      imem[8'h03] = 8'hFB;   // J -> FF
      imem[8'hFF] = 8'h12;   // ALU at FF -> 00
      start_run();
      do_instruction(0, 1'b0, 1'b1);
      do_instruction(0, 1'b1, 1'b1);   // taken: 04
      do_instruction(0, 1'b0, 1'b1);
      do_instruction(0, 1'b0, 1'b1);   // not taken: 06
      do_instruction(0, 1'b0, 1'b1);
      do_instruction(0, 1'b0, 1'b1);
      do_instruction(0, 1'b0, 1'b1);
      do_instruction(0, 1'b0, 1'b1);
   endtask

   task automatic test_stall_and_run_low();
      apply_reset();
      imem[0] = 8'h41;
      imem[1] = 8'h05;
      start_run();
      do_instruction(4, 1'b0, 1'b1);
      do_instruction(2, 1'b0, 1'b0);   // Run dropped during FETCH
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (fetch_req !== 1'b0 || pc !== 8'h02) begin
            fails++;
            $display("FAIL run_low_idle: fetch_req=%b pc=%h required 0 02", fetch_req, pc);
         end
      end
      start_run();
   endtask

   task automatic test_clear_exec();
      apply_reset();
      imem[0] = 8'h00;
      imem[1] = 8'h01;
      start_run();
      do_instruction(0, 1'b0, 1'b1);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tests++;
      if (reg_write !== 1'b1 || pc !== 8'h01) begin
         fails++;
         $display("FAIL clear_precond: reg_write=%b pc=%h required 1 01", reg_write, pc);
      end
      run = 1'b0;
      #2 clear = 1'b1;
      #1;
      tests++;
      if (pc !== 8'h00 || reg_write !== 1'b0 || fetch_req !== 1'b0) begin
         fails++;
         $display("FAIL async_clear: pc=%h reg_write=%b fetch_req=%b required 00 0 0", pc, reg_write, fetch_req);
      end
      @(negedge clk);
      clear = 1'b0;
      tick();
      tests++;
      if (pc !== 8'h00 || reg_write !== 1'b0 || fetch_req !== 1'b0) begin
         fails++;
         $display("FAIL clear_idle: pc=%h reg_write=%b fetch_req=%b required 00 0 0", pc, reg_write, fetch_req);
      end
   endtask

   task automatic test_halt();
      apply_reset();
      imem[8'h00] = 8'hCF;   // J -> 10
      imem[8'h10] = 8'hFF;
      start_run();
      do_instruction(0, 1'b0, 1'b1);
      do_instruction(0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step = i[0];
         tick();
         tests++;
         if (halted !== 1'b1 || pc !== 8'h10 || fetch_req !== 1'b0 || pc_added !== 8'(exp_added)) begin
            fails++;
            $display("FAIL halt_hold: halted=%b pc=%h fetch_req=%b pc_added=%h required 1 10 0 %h",
                     halted, pc, fetch_req, pc_added, 8'(exp_added));
         end
      end
      step = 1'b0;
      imem[8'h10] = 8'h00;
   endtask

   task automatic test_random();
      logic [7:0] insn;
      apply_reset();
      start_run();
      for (int n = 0; n < 60; n++) begin
         insn = 8'($urandom_range(0, 254));
         imem[exp_pc[7:0]] = insn;
         do_instruction(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 8'h00;
      clear = 1'b1; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; step = 1'b0;
      test_reset();
      test_sequence();
      test_branch_and_wrap();
      test_stall_and_run_low();
      test_clear_exec();
      test_halt();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard stop in case the sequence above ever stalls.
   initial begin
      #500000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
